// File: rtl/btn_pkg.sv
// Shared constants and FSM encoding for the push-button conditioner.
// Default cycle counts assume a 100 MHz system clock.
package btn_pkg;

   localparam int NUM_BTN = 5;

   // 10 ms debounce, 500 ms hold before first repeat, 100 ms between repeats
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_HOLD_CYCLES     = 50000000;
   localparam int DEFAULT_REPEAT_CYCLES   = 10000000;

   // BTN1 (up) and BTN3 (down) auto-repeat by default
   localparam logic [NUM_BTN-1:0] DEFAULT_REPEAT_MASK = 5'b01010;

   // Per-button press tracking: released, held waiting for first repeat, repeating
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_t;

endpackage

// File: rtl/btn_channel.sv
// One push-button lane: two-flop synchronizer, counter debounce, and a
// press/hold/repeat FSM producing one-cycle press and repeat pulses.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic IN_CLK,
   input  logic IN_RST,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic rpt
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);

   logic          sync_meta;
   logic          sync_q;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          level_d;
   logic          rise, fall;
   btn_state_t    state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rpt_d;

   // Bring the asynchronous pin into the clock domain before anything looks at it
   always_ff @(posedge IN_CLK) begin
      if (IN_RST) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         sync_q    <= sync_meta;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      level_d   = level;
      rise      = 1'b0;
      fall      = 1'b0;
      if (sync_q == level) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
         deb_cnt_d = '0;
         level_d   = sync_q;
         rise      = sync_q;
         fall      = ~sync_q;
      end else begin
         deb_cnt_d = deb_cnt_q + DW'(1);
      end
   end

   // Hold/repeat sequencing; a release always wins over a pulse due in the same cycle
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      rpt_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
         ST_HOLD: begin
            if (fall) begin
               state_d = ST_IDLE;
            end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
               if (REPEAT_EN) begin
                  rpt_d     = 1'b1;
                  state_d   = ST_REPEAT;
                  rep_cnt_d = '0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         ST_REPEAT: begin
            if (fall) begin
               state_d = ST_IDLE;
            end else if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
               rpt_d     = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + RW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register debounce state, FSM state and the one-cycle output pulses
   always_ff @(posedge IN_CLK) begin
      if (IN_RST) begin
         deb_cnt_q  <= '0;
         level      <= 1'b0;
         press      <= 1'b0;
         rpt        <= 1'b0;
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
      end else begin
         deb_cnt_q  <= deb_cnt_d;
         level      <= level_d;
         press      <= rise;
         rpt        <= rpt_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Five-button conditioner: per-button debounce with press and auto-repeat
// pulses, plus an ENABLE gate on the pulse outputs (levels always track).
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int                  HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int                  REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = DEFAULT_REPEAT_MASK
) (
   input  logic               IN_CLK,
   input  logic               IN_RST,
   input  logic               ENABLE,
   input  logic [NUM_BTN-1:0] IN_BTN,
   output logic [NUM_BTN-1:0] OUT_LEVEL,
   output logic [NUM_BTN-1:0] OUT_PRESS,
   output logic [NUM_BTN-1:0] OUT_REPEAT,
   output logic [NUM_BTN-1:0] OUT_STROBE
);

   logic [NUM_BTN-1:0] press_int;
   logic [NUM_BTN-1:0] rpt_int;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_chan (
         .IN_CLK  (IN_CLK),
         .IN_RST  (IN_RST),
         .btn_raw (IN_BTN[i]),
         .level   (OUT_LEVEL[i]),
         .press   (press_int[i]),
         .rpt     (rpt_int[i])
      );
   end

   // Gating is combinational so pulses suppressed while disabled are simply lost
   assign OUT_PRESS  = press_int & {NUM_BTN{ENABLE}};
   assign OUT_REPEAT = rpt_int & {NUM_BTN{ENABLE}};
   assign OUT_STROBE = OUT_PRESS | OUT_REPEAT;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/hold/repeat
// times. A window-based reference model predicts every output each cycle.
module tb_btn_conditioner;

   localparam int         DEB  = 4;
   localparam int         HOLD = 20;
   localparam int         REP  = 5;
   localparam logic [4:0] MASK = 5'b01010;

   logic       IN_CLK = 1'b0;
   logic       IN_RST = 1'b1;
   logic       ENABLE = 1'b1;
   logic [4:0] IN_BTN = '0;
   logic [4:0] OUT_LEVEL, OUT_PRESS, OUT_REPEAT, OUT_STROBE;
   logic [19:0] act_vec;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [4:0] raw_d1, raw_d2;
   logic [4:0] samp_win [$];
   logic [4:0] m_level, m_rose, m_rpt;
   int         m_age [5];
   logic       exp_en;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP),
      .REPEAT_MASK     (MASK)
   ) dut (
      .IN_CLK     (IN_CLK),
      .IN_RST     (IN_RST),
      .ENABLE     (ENABLE),
      .IN_BTN     (IN_BTN),
      .OUT_LEVEL  (OUT_LEVEL),
      .OUT_PRESS  (OUT_PRESS),
      .OUT_REPEAT (OUT_REPEAT),
      .OUT_STROBE (OUT_STROBE)
   );

   assign act_vec = {OUT_LEVEL, OUT_PRESS, OUT_REPEAT, OUT_STROBE};

   // 100 MHz clock
   always #5 IN_CLK = ~IN_CLK;

   // Model: a level flips once the last DEB synchronized samples all disagree with it;
   // repeats fall at ages HOLD, HOLD+REP, ... measured from the debounced rise.
   task automatic model_step(input logic [4:0] raw, input logic rst);
      logic [4:0] samp;
      if (rst) begin
         raw_d1  = '0;
         raw_d2  = '0;
         samp_win.delete();
         m_level = '0;
         m_rose  = '0;
         m_rpt   = '0;
         for (int b = 0; b < 5; b++) m_age[b] = -1;
         return;
      end
      samp   = raw_d2;
      raw_d2 = raw_d1;
      raw_d1 = raw;
      samp_win.push_back(samp);
      if (samp_win.size() > DEB) void'(samp_win.pop_front());
      m_rose = '0;
      m_rpt  = '0;
      for (int b = 0; b < 5; b++) begin
         bit flip;
         flip = (samp_win.size() == DEB);
         foreach (samp_win[k]) if (samp_win[k][b] == m_level[b]) flip = 1'b0;
         if (flip) begin
            m_level[b] = ~m_level[b];
            if (m_level[b]) begin
               m_rose[b] = 1'b1;
               m_age[b]  = 0;
            end else begin
               m_age[b] = -1;
            end
         end else if (m_age[b] >= 0) begin
            m_age[b]++;
         end
         if (MASK[b] && m_age[b] >= HOLD && ((m_age[b] - HOLD) % REP) == 0) m_rpt[b] = 1'b1;
      end
   endtask

   function automatic logic [19:0] exp_vec();
      logic [4:0] p, r;
      p = m_rose & {5{exp_en}};
      r = m_rpt & {5{exp_en}};
      return {m_level, p, r, p | r};
   endfunction

   // Drive inputs at the falling edge, step the model at the rising edge, return at the next falling edge
   task automatic drive_cycle(input logic [4:0] btn, input logic en, input logic rst);
      IN_BTN = btn;
      ENABLE = en;
      IN_RST = rst;
      @(posedge IN_CLK);
      model_step(btn, rst);
      exp_en = en;
      @(negedge IN_CLK);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive_cycle(5'b00000, 1'b1, 1'b1);
         vectors++;
         if (act_vec !== 20'h0) begin
            miscompares++;
            $display("[TB] FAIL reset cyc %0d: got %h required %h", c, act_vec, 20'h0);
         end
      end
      for (int c = 0; c < 4; c++) begin
         drive_cycle(5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_idle cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_clean_press();
      int rise_cyc = -1;
      int presses  = 0;
      int repeats  = 0;
      for (int c = 1; c <= 20; c++) begin
         drive_cycle((c <= 10) ? 5'b00100 : 5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL clean_press cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
         if (OUT_LEVEL[2] && rise_cyc < 0) rise_cyc = c;
         if (OUT_PRESS[2]) presses++;
         if (OUT_REPEAT[2]) repeats++;
      end
      vectors++;
      if (rise_cyc !== 6) begin
         miscompares++;
         $display("[TB] FAIL clean_press_latency: got cycle %0d required 6", rise_cyc);
      end
      vectors++;
      if (presses !== 1 || repeats !== 0) begin
         miscompares++;
         $display("[TB] FAIL clean_press_pulses: got %0d press %0d repeat required 1 press 0 repeat", presses, repeats);
      end
   endtask

   task automatic test_glitch();
      int bad = 0;
      for (int c = 0; c < 28; c++) begin
         drive_cycle((c < 20 && (c % 4) != 3) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL glitch cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
         if ({OUT_LEVEL[0], OUT_PRESS[0], OUT_REPEAT[0], OUT_STROBE[0]} !== 4'b0000) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("[TB] FAIL glitch_bit0: got %0d active cycles required 0", bad);
      end
   endtask

   // Hold one button; report press count and repeat offsets relative to the debounced rise
   task automatic hold_and_measure(input logic [4:0] btn, input int bit_idx, input int hold_until,
                                   input string name, output int rise_seen, output int presses,
                                   output int nrep, output int rep_off [8]);
      rise_seen = -1;
      presses   = 0;
      nrep      = 0;
      for (int j = 0; j < 8; j++) rep_off[j] = -1;
      for (int c = 1; c <= 12 && rise_seen < 0; c++) begin
         drive_cycle(btn, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL %s_rise cyc %0d: got %h required %h", name, c, act_vec, exp_vec());
         end
         if (OUT_LEVEL[bit_idx]) rise_seen = c;
         if (OUT_PRESS[bit_idx]) presses++;
      end
      for (int k = 1; k <= hold_until + 25; k++) begin
         drive_cycle((k <= hold_until) ? btn : 5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL %s_hold off %0d: got %h required %h", name, k, act_vec, exp_vec());
         end
         if (OUT_PRESS[bit_idx]) presses++;
         if (OUT_REPEAT[bit_idx]) begin
            if (nrep < 8) rep_off[nrep] = k;
            nrep++;
         end
      end
   endtask

   task automatic test_hold_repeat();
      int rise_seen, presses, nrep;
      int rep_off [8];
      hold_and_measure(5'b00010, 1, 35, "repeat_btn1", rise_seen, presses, nrep, rep_off);
      vectors++;
      if (rise_seen !== 6 || presses !== 1) begin
         miscompares++;
         $display("[TB] FAIL repeat_btn1_press: got rise %0d presses %0d required rise 6 presses 1", rise_seen, presses);
      end
      vectors++;
      if (nrep !== 5) begin
         miscompares++;
         $display("[TB] FAIL repeat_btn1_count: got %0d required 5", nrep);
      end
      for (int j = 0; j < 5; j++) begin
         vectors++;
         if (rep_off[j] !== 20 + 5 * j) begin
            miscompares++;
            $display("[TB] FAIL repeat_btn1_offset %0d: got %0d required %0d", j, rep_off[j], 20 + 5 * j);
         end
      end
   endtask

   task automatic test_unmasked_hold();
      int rise_seen, presses, nrep;
      int rep_off [8];
      hold_and_measure(5'b10000, 4, 45, "unmasked_btn4", rise_seen, presses, nrep, rep_off);
      vectors++;
      if (presses !== 1 || nrep !== 0) begin
         miscompares++;
         $display("[TB] FAIL unmasked_btn4: got %0d press %0d repeat required 1 press 0 repeat", presses, nrep);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] first_press = '0;
      int rep1 = 0;
      int rep3 = 0;
      for (int c = 1; c <= 55; c++) begin
         drive_cycle((c <= 40) ? 5'b01010 : 5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL simultaneous cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
         if (first_press == 5'b00000) first_press = OUT_PRESS;
         if (c <= 40 && OUT_REPEAT[1]) rep1++;
         if (c <= 40 && OUT_REPEAT[3]) rep3++;
      end
      vectors++;
      if (first_press !== 5'b01010) begin
         miscompares++;
         $display("[TB] FAIL simultaneous_press: got %b required %b", first_press, 5'b01010);
      end
      vectors++;
      if (rep1 !== 3 || rep3 !== 3) begin
         miscompares++;
         $display("[TB] FAIL simultaneous_repeat: got %0d/%0d required 3/3", rep1, rep3);
      end
   endtask

   task automatic test_reset_mid_repeat();
      int press_cyc = -1;
      int reps      = 0;
      for (int c = 1; c <= 30; c++) begin
         drive_cycle(5'b01000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_pre cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
      end
      drive_cycle(5'b01000, 1'b1, 1'b1);
      vectors++;
      if (act_vec !== 20'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_clear: got %h required %h", act_vec, 20'h0);
      end
      for (int j = 1; j <= 12; j++) begin
         drive_cycle(5'b01000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_post cyc %0d: got %h required %h", j, act_vec, exp_vec());
         end
         if (OUT_PRESS[3] && press_cyc < 0) press_cyc = j;
         if (OUT_REPEAT[3]) reps++;
      end
      vectors++;
      if (press_cyc !== 6 || reps !== 0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_repress: got press at %0d with %0d repeats required 6 with 0", press_cyc, reps);
      end
      for (int j = 0; j < 15; j++) drive_cycle(5'b00000, 1'b1, 1'b0);
   endtask

   task automatic test_enable_gate();
      int level_cyc = -1;
      int pulses    = 0;
      for (int c = 1; c <= 29; c++) begin
         drive_cycle(5'b00110, (c > 26), 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL enable cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
         if (OUT_LEVEL[2] && level_cyc < 0) level_cyc = c;
         if (OUT_STROBE !== 5'b00000 || OUT_PRESS !== 5'b00000 || OUT_REPEAT !== 5'b00000) pulses++;
      end
      vectors++;
      if (level_cyc !== 6 || pulses !== 0) begin
         miscompares++;
         $display("[TB] FAIL enable_gate: got level at %0d with %0d pulse cycles required 6 with 0", level_cyc, pulses);
      end
      for (int c = 0; c < 15; c++) begin
         drive_cycle(5'b00000, 1'b1, 1'b0);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL enable_tail cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] btn = '0;
      logic       en  = 1'b1;
      logic       rst;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 5; b++) if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
         if ($urandom_range(0, 39) == 0) en = ~en;
         rst = ($urandom_range(0, 299) == 0);
         drive_cycle(btn, en, rst);
         vectors++;
         if (act_vec !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL random cyc %0d: got %h required %h", c, act_vec, exp_vec());
         end
      end
   endtask

   initial begin
      @(negedge IN_CLK);
      test_reset();
      test_clean_press();
      test_glitch();
      test_hold_repeat();
      test_unmasked_hold();
      test_back_to_back();
      test_reset_mid_repeat();
      test_enable_gate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000, hold time before the first auto-repeat pulse (500 ms).
REQ-003 Parameter REPEAT_CYCLES, default 10000000, interval between later auto-repeat pulses (100 ms).
REQ-004 Parameter REPEAT_MASK, default 5'b01010, buttons with auto-repeat enabled (BTN1 up, BTN3 down).
REQ-005 IN_CLK  input  1  system clock, 100 MHz, all logic on its rising edge.
REQ-006 IN_RST  input  1  reset, synchronous and active-high.
REQ-007 ENABLE  input  1  output gate; when low, OUT_PRESS, OUT_REPEAT and OUT_STROBE are forced to 0 while internal tracking continues.
REQ-008 IN_BTN  input  5  raw asynchronous push-button pins, active-high.
REQ-009 OUT_LEVEL  output  5  debounced button level.
REQ-010 OUT_PRESS  output  5  one-cycle pulse on each debounced rising edge.
REQ-011 OUT_REPEAT  output  5  one-cycle auto-repeat pulses for masked buttons.
REQ-012 OUT_STROBE  output  5  OUT_PRESS | OUT_REPEAT, for direct use as a step command by the timer.

Function
REQ-013 Each IN_BTN bit shall pass through a two-flop synchronizer before any other use.
REQ-014 Each bit shall keep a debounce counter; the counter clears whenever the synchronized sample equals OUT_LEVEL.
REQ-015 The counter increments while the sample differs from OUT_LEVEL; on reaching DEBOUNCE_CYCLES, OUT_LEVEL takes the sample and the counter clears.
REQ-016 Raw-to-OUT_LEVEL latency shall be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES samples shall produce no output change.
REQ-018 OUT_PRESS[i] shall assert in the same cycle that OUT_LEVEL[i] rises, for exactly one cycle.
REQ-019 Each bit shall run a three-state FSM: IDLE (level 0), HOLD (level 1, hold timer running), REPEAT (level 1, repeat timer running).
REQ-020 IDLE goes to HOLD on the debounced rise, and the hold timer clears.
REQ-021 In HOLD, when the timer reaches HOLD_CYCLES and REPEAT_MASK[i]=1, the FSM asserts OUT_REPEAT[i] for one cycle and enters REPEAT; unmasked bits stay in HOLD with no pulse.
REQ-022 In REPEAT, the FSM asserts OUT_REPEAT[i] every REPEAT_CYCLES cycles while the level stays 1.
REQ-023 A debounced fall in any state shall return the FSM to IDLE in that cycle and suppress any repeat pulse due in that cycle.
REQ-024 Bits shall be fully independent; simultaneous presses each yield their own pulses in the same cycle.
REQ-025 Counter widths shall be clog2(parameter + 1), and no counter shall wrap.
REQ-026 While ENABLE is low, pulses are dropped, not queued; raising ENABLE shall not emit deferred pulses.

Reset
REQ-027 When IN_RST=1 at a clock edge, all synchronizer flops, counters, OUT_LEVEL, OUT_PRESS, OUT_REPEAT and OUT_STROBE shall become 0 and all FSMs shall enter IDLE.
REQ-028 A button held through reset release shall be treated as a fresh press and generate OUT_PRESS after 2 + DEBOUNCE_CYCLES cycles.
REQ-029 Reset asserted mid-HOLD or mid-REPEAT shall abort the operation with no further pulses.

Structure
REQ-030 The FSM state encoding (IDLE/HOLD/REPEAT) and the default cycle constants shall live in shared package btn_pkg.
REQ-031 A per-bit sub-module btn_channel (synchronizer, debounce, FSM, timers) shall be instantiated 5 times, with REPEAT_MASK[i] passed as its repeat-enable parameter.

Verification
Benches use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
REQ-032 Clean press of BTN2 for 10 cycles -> OUT_LEVEL[2] rises at cycle 6 with a single OUT_PRESS[2] pulse; no OUT_REPEAT.
REQ-033 BTN0 toggled high 3 cycles, low 1 cycle, repeated 5 times -> OUT_LEVEL[0] and all pulses stay 0.
REQ-034 BTN1 held 40 cycles after acceptance -> one PRESS, then REPEAT pulses at +20, +25, +30, +35 and +40 cycles after the rise, none after release.
REQ-035 BTN4 held 40 cycles (unmasked) -> exactly one PRESS and zero REPEAT pulses.
REQ-036 BTN1 and BTN3 pressed in the same cycle -> PRESS[1] and PRESS[3] in the same cycle, with aligned repeats.
REQ-037 IN_RST pulsed 1 cycle during BTN3 REPEAT while still held -> outputs 0 immediately, new PRESS 6 cycles later; with ENABLE=0 across a press -> no pulses, OUT_LEVEL still tracks.
